uart_reg_file: RTL and testbench

UART register file sitting directly downstream of the APB slave. It decodes the qualified APB transfer fields (select, enable, write, address, strobe and write data) and answers with one-cycle write/read enable handshakes and registered read data. It also returns a sticky parity-error flag. It holds the TX data, configuration and control registers that drive the UART core, and captures RX data and status from the core.

---
 rtl/uart_reg_file_if.sv | 22 ++
 rtl/uart_reg_file.sv | 175 +++++++++++++++++
 tb/tb_uart_reg_file.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_file_if.sv
// rtl/uart_reg_file_if.sv - Qualified APB transfer fields and access-done handshake for the UART register file
interface uart_reg_file_if;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [11:0] paddr_i;
    logic [3:0]  pstrb_i;
    logic [31:0] pwdata_i;
    logic        write_en_o;
    logic        read_en_o;
    logic [31:0] prdata_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pstrb_i, pwdata_i,
        input  write_en_o, read_en_o, prdata_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pstrb_i, pwdata_i,
        output write_en_o, read_en_o, prdata_o
    );
endinterface

// File: rtl/uart_reg_file.sv
// rtl/uart_reg_file.sv - UART register file behind the APB slave; optional CTRL[1] loopback via UART_REGS_LOOPBACK_EN
module uart_reg_file #(
    parameter logic [7:0]  CFG_RST  = 8'h03,
    parameter logic [11:0] ADDR_MAX = 12'h010
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_reg_file_if.slave   bus,
    output logic [7:0]       tx_data_o,
    output logic [1:0]       data_bits_o,
    output logic             stop_bits_o,
    output logic             parity_en_o,
    output logic             parity_type_o,
    output logic             start_tx_o,
    output logic             loopback_o,
    output logic             parity_error_o,
    input  logic             tx_busy_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_done_i,
    input  logic             parity_err_i
);

    localparam logic [11:0] A_TX   = 12'h000;
    localparam logic [11:0] A_RX   = 12'h004;
    localparam logic [11:0] A_CFG  = 12'h008;
    localparam logic [11:0] A_CTRL = 12'h00C;
    localparam logic [11:0] A_STT  = 12'h010;

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

    state_t      state;
    logic [7:0]  tx_data;
    logic [4:0]  cfg;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overrun;
    logic        parity_error;
    logic        write_en;
    logic        read_en;
    logic        start_tx;
    logic [31:0] prdata;
    logic [11:0] ack_addr;
    logic        ack_read;
    logic        loopback_r;

    logic        addr_ok;
    logic        wr_ok;
    logic        rd_ok;
    logic        access;
    logic        rd_clr_rx;
    logic        rd_clr_stt;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign addr_ok = (bus.paddr_i <= ADDR_MAX) && (bus.paddr_i[1:0] == 2'b00);
    assign wr_ok   = bus.pwrite_i && addr_ok &&
                     (bus.paddr_i == A_TX || bus.paddr_i == A_CFG || bus.paddr_i == A_CTRL);
    assign rd_ok   = !bus.pwrite_i && addr_ok;
    assign access  = (state == IDLE) && bus.psel_i && bus.penable_i && (wr_ok || rd_ok);

    // Read side effects land on the ACK exit edge so status stays stable through the access
    assign rd_clr_rx  = (state == ACK) && ack_read && (ack_addr == A_RX);
    assign rd_clr_stt = (state == ACK) && ack_read && (ack_addr == A_STT);

    assign unused_bits = ^{bus.pwdata_i[31:8], bus.pstrb_i[3:1]};

    always_comb begin
        rd_mux = '0;
        case (bus.paddr_i)
            A_TX:    rd_mux[7:0] = tx_data;
            A_RX:    rd_mux[7:0] = rx_data;
            A_CFG:   rd_mux[4:0] = cfg;
            A_CTRL:  rd_mux[1]   = loopback_r;
            A_STT:   rd_mux[3:0] = {parity_error, rx_overrun, rx_valid, tx_busy_i};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            tx_data      <= '0;
            cfg          <= CFG_RST[4:0];
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            parity_error <= 1'b0;
            write_en     <= 1'b0;
            read_en      <= 1'b0;
            start_tx     <= 1'b0;
            prdata       <= '0;
            ack_addr     <= '0;
            ack_read     <= 1'b0;
`ifdef UART_REGS_LOOPBACK_EN
            loopback_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        state    <= ACK;
                        ack_addr <= bus.paddr_i;
                        ack_read <= !bus.pwrite_i;
                        if (bus.pwrite_i) begin
                            write_en <= 1'b1;
                            if (bus.pstrb_i[0]) begin
                                case (bus.paddr_i)
                                    A_TX:  tx_data <= bus.pwdata_i[7:0];
                                    A_CFG: cfg     <= bus.pwdata_i[4:0];
                                    A_CTRL: begin
`ifdef UART_REGS_LOOPBACK_EN
                                        loopback_r <= bus.pwdata_i[1];
`endif
                                        start_tx <= bus.pwdata_i[0] && !tx_busy_i;
                                    end
                                    default: ;
                                endcase
                            end
                        end else begin
                            read_en <= 1'b1;
                            prdata  <= rd_mux;
                        end
                    end
                end
                ACK: begin
                    write_en <= 1'b0;
                    read_en  <= 1'b0;
                    start_tx <= 1'b0;
                    ack_read <= 1'b0;
                    state    <= bus.penable_i ? WAIT : IDLE;
                end
                WAIT: begin
                    if (!bus.penable_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Incoming events always win over a read-clear in the same cycle
            if (rx_done_i) begin
                rx_data  <= rx_data_i;
                rx_valid <= 1'b1;
            end else if (rd_clr_rx) begin
                rx_valid <= 1'b0;
            end

            if (rx_done_i && rx_valid && !rd_clr_rx)
                rx_overrun <= 1'b1;
            else if (rd_clr_stt)
                rx_overrun <= 1'b0;

            if (parity_err_i)
                parity_error <= 1'b1;
            else if (rd_clr_stt)
                parity_error <= 1'b0;
        end
    end

`ifndef UART_REGS_LOOPBACK_EN
    assign loopback_r = 1'b0;
`endif

    assign bus.write_en_o = write_en;
    assign bus.read_en_o  = read_en;
    assign bus.prdata_o   = prdata;
    assign tx_data_o      = tx_data;
    assign data_bits_o    = cfg[1:0];
    assign stop_bits_o    = cfg[2];
    assign parity_en_o    = cfg[3];
    assign parity_type_o  = cfg[4];
    assign start_tx_o     = start_tx;
    assign loopback_o     = loopback_r;
    assign parity_error_o = parity_error;

endmodule

// File: tb/tb_uart_reg_file.sv
// tb/tb_uart_reg_file.sv - Directed self-checking bench for uart_reg_file
module tb_uart_reg_file;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data_o;
    logic [1:0] data_bits_o;
    logic       stop_bits_o, parity_en_o, parity_type_o, start_tx_o, loopback_o, parity_error_o;
    logic       tx_busy_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_done_i = 1'b0;
    logic       parity_err_i = 1'b0;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          en_cnt;
    int          st_cnt;
    logic        par_hold;
    logic [31:0] rdata;
    logic [31:0] prd_before;

    uart_reg_file_if bus();

    uart_reg_file dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .tx_data_o      (tx_data_o),
        .data_bits_o    (data_bits_o),
        .stop_bits_o    (stop_bits_o),
        .parity_en_o    (parity_en_o),
        .parity_type_o  (parity_type_o),
        .start_tx_o     (start_tx_o),
        .loopback_o     (loopback_o),
        .parity_error_o (parity_error_o),
        .tx_busy_i      (tx_busy_i),
        .rx_data_i      (rx_data_i),
        .rx_done_i      (rx_done_i),
        .parity_err_i   (parity_err_i)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One APB access held through ACK into WAIT; ack_pulse fires parity_err_i/rx_done_i in the ACK cycle
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] ack_pulse);
        en_cnt   = 0;
        st_cnt   = 0;
        rdata    = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b1;
        bus.pwrite_i  = wr;
        bus.paddr_i   = addr;
        bus.pwdata_i  = data;
        bus.pstrb_i   = strb;
        #1 par_hold = parity_error_o;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.write_en_o || bus.read_en_o) en_cnt++;
            if (bus.read_en_o) rdata = bus.prdata_o;
            if (start_tx_o) st_cnt++;
            if (i == 0) begin
                par_hold     = par_hold & parity_error_o;
                parity_err_i = ack_pulse[0];
                rx_done_i    = ack_pulse[1];
            end
            if (i == 1) begin
                parity_err_i  = 1'b0;
                rx_done_i     = 1'b0;
                bus.psel_i    = 1'b0;
                bus.penable_i = 1'b0;
            end
        end
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(negedge clk);
        rx_data_i = d;
        rx_done_i = 1'b1;
        @(negedge clk);
        rx_done_i = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        xfer(1'b0, addr, 32'h0, 4'h0, 2'b00);
        check_val(tag, rdata, exp);
    endtask

    initial begin
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = '0; bus.pstrb_i = '0; bus.pwdata_i = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_val("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
        check_val("rst_cfg", {27'h0, parity_type_o, parity_en_o, stop_bits_o, data_bits_o}, 32'h03);
        check_val("rst_ctl", {28'h0, start_tx_o, loopback_o, parity_error_o, bus.write_en_o | bus.read_en_o}, 32'h0);
        check_val("rst_prdata", bus.prdata_o, 32'h0);

        xfer(1'b0, 12'h008, 32'h0, 4'h0, 2'b00);
        check_val("rd_cfg", rdata, 32'h03);
        check_val("rd_cfg_en", en_cnt, 1);
        rd_check("rd_stt_rst", 12'h010, 32'h0);

        xfer(1'b1, 12'h000, 32'hA5, 4'h1, 2'b00);
        check_val("wr_tx", {24'h0, tx_data_o}, 32'hA5);
        xfer(1'b1, 12'h000, 32'h11, 4'h0, 2'b00);
        check_val("wr_tx_nostrb", {24'h0, tx_data_o}, 32'hA5);
        check_val("wr_tx_nostrb_en", en_cnt, 1);

        xfer(1'b1, 12'h00C, 32'h1, 4'h1, 2'b00);
        check_val("start_pulse", st_cnt, 1);
        tx_busy_i = 1'b1;
        xfer(1'b1, 12'h00C, 32'h1, 4'h1, 2'b00);
        check_val("start_busy", st_cnt, 0);
        tx_busy_i = 1'b0;
        rd_check("rd_ctrl", 12'h00C, 32'h0);

        xfer(1'b1, 12'h008, 32'hFFFF_FF1A, 4'h1, 2'b00);
        check_val("cfg_out", {27'h0, parity_type_o, parity_en_o, stop_bits_o, data_bits_o}, 32'h1A);
        rd_check("rd_cfg_1a", 12'h008, 32'h1A);
        rd_check("rd_tx", 12'h000, 32'hA5);

        rx_pulse(8'h3C);
        rx_pulse(8'h5A);
        rd_check("rd_rx_5a", 12'h004, 32'h5A);
        rd_check("stt_ovr", 12'h010, 32'h4);
        rd_check("stt_clr", 12'h010, 32'h0);

        rx_pulse(8'h01);
        rx_pulse(8'h02);
        rd_check("stt_6", 12'h010, 32'h6);
        rd_check("stt_2", 12'h010, 32'h2);
        rd_check("rd_rx_02", 12'h004, 32'h02);
        rd_check("stt_0", 12'h010, 32'h0);

        rx_pulse(8'h11);
        rx_data_i = 8'h22;
        xfer(1'b0, 12'h004, 32'h0, 4'h0, 2'b10);
        check_val("rx_coll_data", rdata, 32'h11);
        rd_check("rx_coll_stt", 12'h010, 32'h2);
        rd_check("rx_coll_new", 12'h004, 32'h22);

        @(negedge clk); parity_err_i = 1'b1;
        @(negedge clk); parity_err_i = 1'b0;
        check_val("par_set", {31'h0, parity_error_o}, 32'h1);
        xfer(1'b0, 12'h010, 32'h0, 4'h0, 2'b00);
        check_val("par_stt", rdata, 32'h8);
        check_val("par_hold", {31'h0, par_hold}, 32'h1);
        check_val("par_clr", {31'h0, parity_error_o}, 32'h0);
        @(negedge clk); parity_err_i = 1'b1;
        @(negedge clk); parity_err_i = 1'b0;
        xfer(1'b0, 12'h010, 32'h0, 4'h0, 2'b01);
        check_val("par_coll", {31'h0, parity_error_o}, 32'h1);
        rd_check("par_stt2", 12'h010, 32'h8);

        prd_before = bus.prdata_o;
        xfer(1'b1, 12'h004, 32'hFF, 4'h1, 2'b00);
        check_val("wr_ro_en", en_cnt, 0);
        xfer(1'b1, 12'h014, 32'hFF, 4'h1, 2'b00);
        check_val("wr_unmap_en", en_cnt, 0);
        xfer(1'b0, 12'h002, 32'h0, 4'h0, 2'b00);
        check_val("rd_misalign_en", en_cnt, 0);
        check_val("rd_misalign_prd", bus.prdata_o, prd_before);
        rd_check("rx_unchanged", 12'h004, 32'h22);
        check_val("tx_unchanged", {24'h0, tx_data_o}, 32'hA5);

        @(negedge clk);
        bus.psel_i = 1'b1; bus.penable_i = 1'b1; bus.pwrite_i = 1'b1;
        bus.paddr_i = 12'h000; bus.pwdata_i = 32'h77; bus.pstrb_i = 4'h1;
        @(posedge clk); #1;
        check_val("ack_wr_en", {31'h0, bus.write_en_o}, 32'h1);
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_tx", {24'h0, tx_data_o}, 32'h0);
        check_val("rst_mid_en", {31'h0, bus.write_en_o}, 32'h0);
        check_val("rst_mid_cfg", {27'h0, parity_type_o, parity_en_o, stop_bits_o, data_bits_o}, 32'h03);
        check_val("rst_mid_prd", bus.prdata_o, 32'h0);
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        rd_check("rst_mid_stt", 12'h010, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
